// File: rtl/layer_arb_pkg.sv
// layer_arb_pkg: shared types, constants and default slot table for the layer arbiter
package layer_arb_pkg;
    localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;
    // Slot layer field is sized for the largest supported table (8 layers)
    localparam int MAX_IDX_W = 3;
    typedef struct packed {
        logic                 en;
        logic [MAX_IDX_W-1:0] layer;
    } slot_t;
    typedef enum logic {OPEN, COMMIT} cfg_state_t;
    function automatic slot_t default_slot(input int i);
        return '{en: 1'b1, layer: MAX_IDX_W'(i)};
    endfunction
endpackage

// File: rtl/layer_priority_arbiter_if.sv
// layer_priority_arbiter_if: pixel, config and collision signals of the layer arbiter
interface layer_priority_arbiter_if #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = $clog2(NUM_LAYERS)
);
    logic [NUM_LAYERS-1:0]   drawingRequest;
    logic [NUM_LAYERS*8-1:0] layerRGB;
    logic [7:0]              backGroundRGB;
    logic                    startOfFrame;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [IDX_W-1:0]        cfg_slot;
    logic [IDX_W-1:0]        cfg_layer;
    logic                    cfg_enable;
    logic [7:0]              rgbOut;
    logic [IDX_W-1:0]        winnerLayer;
    logic                    winnerValid;
    logic [NUM_LAYERS-1:0]   collisionOut;
    logic                    collisionValid;
    modport master (
        output drawingRequest, layerRGB, backGroundRGB, startOfFrame,
        output cfg_valid, cfg_slot, cfg_layer, cfg_enable,
        input  cfg_ready, rgbOut, winnerLayer, winnerValid, collisionOut, collisionValid
    );
    modport slave (
        input  drawingRequest, layerRGB, backGroundRGB, startOfFrame,
        input  cfg_valid, cfg_slot, cfg_layer, cfg_enable,
        output cfg_ready, rgbOut, winnerLayer, winnerValid, collisionOut, collisionValid
    );
endinterface

// File: rtl/prio_slot_select.sv
// prio_slot_select: first enabled slot whose layer is opaque wins; lowest slot = highest priority
module prio_slot_select
    import layer_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  slot_t [N-1:0]    slots_i,
    input  logic  [N-1:0]    opaque_i,
    output logic  [IDX_W-1:0] winner_o,
    output logic             valid_o
);
    // Scan from the lowest priority up so the highest-priority match is written last
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int s = N - 1; s >= 0; s--)
            for (int l = 0; l < N; l++)
                if (slots_i[s].en && slots_i[s].layer == MAX_IDX_W'(l) && opaque_i[l]) begin
                    winner_o = IDX_W'(l);
                    valid_o  = 1'b1;
                end
    end
endmodule

// File: rtl/layer_priority_arbiter.sv
// layer_priority_arbiter: per-pixel layer priority mux with frame-aligned table commits
// and per-frame opaque-overlap reporting.
module layer_priority_arbiter
    import layer_arb_pkg::*;
#(
    parameter int         NUM_LAYERS  = 4,
    parameter logic [7:0] TRANSPARENT = TRANSPARENT_RGB,
    parameter int         IDX_W       = $clog2(NUM_LAYERS)
) (
    input logic clk,
    input logic resetN,
    layer_priority_arbiter_if.slave arb
);
    slot_t [NUM_LAYERS-1:0]      active_q, shadow_q;
    cfg_state_t                  state_q;
    logic                        dirty_q, cfg_ready_q, cfg_acc;
    logic [NUM_LAYERS-1:0]       opaque_d, opaque_q, hit_d, acc_q, coll_q;
    logic [NUM_LAYERS-1:0][7:0]  rgb_q;
    logic [7:0]                  bg_q, rgb_out_q;
    logic [IDX_W-1:0]            win_d, win_q;
    logic                        win_vld_d, win_vld_q, coll_vld_q;

    always_comb begin
        opaque_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            opaque_d[i] = arb.drawingRequest[i] && arb.layerRGB[8*i +: 8] != TRANSPARENT;
    end

    assign hit_d   = ($countones(opaque_q) > 1) ? opaque_q : '0;
    assign cfg_acc = arb.cfg_valid && cfg_ready_q;

    prio_slot_select #(.N(NUM_LAYERS), .IDX_W(IDX_W)) u_sel (
        .slots_i (active_q),
        .opaque_i(opaque_q),
        .winner_o(win_d),
        .valid_o (win_vld_d)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            opaque_q  <= '0;
            rgb_q     <= '0;
            bg_q      <= '0;
            rgb_out_q <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            opaque_q  <= opaque_d;
            rgb_q     <= arb.layerRGB;
            bg_q      <= arb.backGroundRGB;
            rgb_out_q <= win_vld_d ? rgb_q[win_d] : bg_q;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q      <= '0;
            coll_q     <= '0;
            coll_vld_q <= 1'b0;
        end else begin
            acc_q      <= arb.startOfFrame ? '0 : acc_q | hit_d;
            coll_q     <= arb.startOfFrame ? acc_q | hit_d : coll_q;
            coll_vld_q <= arb.startOfFrame;
        end
    end

    // A write landing on the startOfFrame cycle must join this frame's commit
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= OPEN;
            cfg_ready_q <= 1'b1;
            dirty_q     <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_q[i] <= default_slot(i);
                active_q[i] <= default_slot(i);
            end
        end else if (state_q == COMMIT) begin
            active_q    <= shadow_q;
            dirty_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
            state_q     <= OPEN;
        end else begin
            if (cfg_acc) begin
                shadow_q[arb.cfg_slot] <= '{en: arb.cfg_enable, layer: MAX_IDX_W'(arb.cfg_layer)};
                dirty_q                <= 1'b1;
            end
            if (arb.startOfFrame && (dirty_q || cfg_acc)) begin
                state_q     <= COMMIT;
                cfg_ready_q <= 1'b0;
            end
        end
    end

    assign arb.cfg_ready      = cfg_ready_q;
    assign arb.rgbOut         = rgb_out_q;
    assign arb.winnerLayer    = win_q;
    assign arb.winnerValid    = win_vld_q;
    assign arb.collisionOut   = coll_q;
    assign arb.collisionValid = coll_vld_q;
endmodule

// File: tb/tb_layer_priority_arbiter.sv
// tb_layer_priority_arbiter: directed checks of priority, frame-aligned config commit and collisions
module tb_layer_priority_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    layer_priority_arbiter_if #(.NUM_LAYERS(N)) bus ();
    layer_priority_arbiter #(.NUM_LAYERS(N)) dut (.clk(clk), .resetN(resetN), .arb(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [3:0] dr, input logic [31:0] rgb, input logic [7:0] bg);
        bus.drawingRequest = dr;
        bus.layerRGB       = rgb;
        bus.backGroundRGB  = bg;
    endtask

    task automatic cfg(input logic v, input logic [1:0] s, input logic [1:0] l, input logic e);
        bus.cfg_valid  = v;
        bus.cfg_slot   = s;
        bus.cfg_layer  = l;
        bus.cfg_enable = e;
    endtask

    task automatic win(input string tag, input logic [7:0] rgb, input logic [1:0] w, input logic v);
        chk({tag, "_rgb"}, bus.rgbOut, rgb);
        chk({tag, "_win"}, bus.winnerLayer, w);
        chk({tag, "_vld"}, bus.winnerValid, v);
    endtask

    initial begin
        pix(4'b0000, 32'h0, 8'h00);
        cfg(1'b0, 2'd0, 2'd0, 1'b0);
        bus.startOfFrame = 1'b0;
        tick(2);
        win("rst", 8'h00, 2'd0, 1'b0);
        chk("rst_coll", bus.collisionOut, 4'b0000);
        chk("rst_collv", bus.collisionValid, 1'b0);
        chk("rst_ready", bus.cfg_ready, 1'b1);
        resetN = 1'b1;

        // default table: layer 0 beats layer 2
        pix(4'b0101, 32'hFF_E0_FF_1C, 8'h00);
        tick(2);
        win("dflt", 8'h1C, 2'd0, 1'b1);

        // transparent layer 0 loses to layer 1
        pix(4'b0011, 32'hFF_FF_03_FF, 8'h00);
        tick(2);
        win("transp", 8'h03, 2'd1, 1'b1);

        pix(4'b0000, 32'hFF_FF_03_FF, 8'h92);
        tick(2);
        win("bg", 8'h92, 2'd0, 1'b0);

        // slot0 = layer3 staged mid-frame, committed at next frame start
        pix(4'b1001, 32'h4A_FF_FF_1C, 8'h00);
        cfg(1'b1, 2'd0, 2'd3, 1'b1);
        tick();
        cfg(1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        win("staged", 8'h1C, 2'd0, 1'b1);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("commit_ready0", bus.cfg_ready, 1'b0);
        tick();
        chk("commit_ready1", bus.cfg_ready, 1'b1);
        tick();
        win("committed", 8'h4A, 2'd3, 1'b1);

        // write at startOfFrame joins the commit; write during COMMIT waits
        pix(4'b1011, 32'h4A_FF_03_1C, 8'h00);
        cfg(1'b1, 2'd0, 2'd3, 1'b0);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        cfg(1'b1, 2'd1, 2'd0, 1'b1);
        chk("hold_ready0", bus.cfg_ready, 1'b0);
        tick();
        chk("hold_ready1", bus.cfg_ready, 1'b1);
        tick();
        cfg(1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        win("sof_write", 8'h03, 2'd1, 1'b1);
        tick(2);
        win("held_staged", 8'h03, 2'd1, 1'b1);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick(3);
        win("held_applied", 8'h1C, 2'd0, 1'b1);

        // collisions: clear accumulator, then one overlapping pixel
        pix(4'b0000, 32'hFF_FF_FF_FF, 8'h00);
        tick(2);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("clr_collv", bus.collisionValid, 1'b1);
        tick();
        chk("clr_collv0", bus.collisionValid, 1'b0);
        pix(4'b0110, 32'hFF_E0_03_FF, 8'h00);
        tick();
        pix(4'b0000, 32'hFF_FF_FF_FF, 8'h00);
        tick(3);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("coll_out", bus.collisionOut, 4'b0110);
        chk("coll_vld", bus.collisionValid, 1'b1);
        tick();
        chk("coll_vld_pulse", bus.collisionValid, 1'b0);
        chk("coll_hold", bus.collisionOut, 4'b0110);
        pix(4'b0001, 32'hFF_FF_FF_1C, 8'h00);
        tick(3);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("nocoll_out", bus.collisionOut, 4'b0000);
        chk("nocoll_vld", bus.collisionValid, 1'b1);

        // reset drops a staged write
        pix(4'b0101, 32'hFF_E0_FF_1C, 8'h00);
        cfg(1'b1, 2'd0, 2'd2, 1'b1);
        tick();
        cfg(1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        win("pre_rst", 8'h1C, 2'd0, 1'b1);
        resetN = 1'b0;
        #2;
        win("async_rst", 8'h00, 2'd0, 1'b0);
        chk("async_rst_ready", bus.cfg_ready, 1'b1);
        chk("async_rst_coll", bus.collisionOut, 4'b0000);
        #2;
        resetN = 1'b1;
        tick(2);
        win("post_rst", 8'h1C, 2'd0, 1'b1);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("post_rst_clean", bus.cfg_ready, 1'b1);
        tick(2);
        win("post_rst_tbl", 8'h1C, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
